// File: rtl/ads5296_tx_framer_if.sv
// Sample, control and framed-lane signals between an ADS5296 emulation source and its transmit framer.
interface ads5296_tx_framer_if #(
  parameter int G_NUM_UNITS = 4
);
  logic                       sync;
  logic [1:0]                 mode;
  logic [9:0]                 pattern;
  logic [40*G_NUM_UNITS-1:0]  din;
  logic [40*G_NUM_UNITS-1:0]  lane_bits;
  logic [4:0]                 fclk_bits;
  logic                       phase;
  logic                       sync_out;

  modport master (
    output sync, mode, pattern, din,
    input  lane_bits, fclk_bits, phase, sync_out
  );

  modport slave (
    input  sync, mode, pattern, din,
    output lane_bits, fclk_bits, phase, sync_out
  );
endinterface

// File: rtl/ads5296_tx_framer.sv
// ADS5296 2-wire transmit framer: pairs even/odd samples per channel onto two lanes as 5-bit chunks.
// ADS5296_TX_PRBS_EN selects PRBS-9 for mode 3; otherwise mode 3 sends the deskew word.
module ads5296_tx_framer #(
  parameter int G_NUM_UNITS = 4,
  parameter int G_RAMP_STEP = 1
) (
  input  logic                  sclk2_in,
  input  logic                  rst,
  ads5296_tx_framer_if.slave    bus
);
  localparam int NCH = 4 * G_NUM_UNITS;
  localparam logic [9:0] RAMP_INC = 10'(G_RAMP_STEP % 1024);

  logic       phase_q;
  logic       sync_q;
  logic       sync_out_q;
  logic       tx_vld;
  logic [1:0] mode_q;
  logic [9:0] ramp_q;
  logic [9:0] gen3;
  logic       sync_edge;
  logic [1:0] mode_eff;
  logic [9:0] src   [NCH];
  logic [9:0] cap_a [NCH];
  logic [9:0] tx_a  [NCH];
  logic [9:0] tx_b  [NCH];

  assign sync_edge = bus.sync & ~sync_q;
  // Mode is taken live in phase 0 and held for the odd half so a pair never mixes sources.
  assign mode_eff  = phase_q ? mode_q : bus.mode;

`ifdef ADS5296_TX_PRBS_EN
  logic [8:0] prbs_q;
  logic [8:0] prbs_nxt;
  logic [9:0] prbs_word;

  always_comb begin
    prbs_nxt  = prbs_q;
    prbs_word = '0;
    for (int i = 0; i < 10; i++) begin
      prbs_word = {prbs_word[8:0], prbs_nxt[8] ^ prbs_nxt[4]};
      prbs_nxt  = {prbs_nxt[7:0], prbs_nxt[8] ^ prbs_nxt[4]};
    end
  end

  always_ff @(posedge sclk2_in) begin
    if (rst || sync_edge) begin
      prbs_q <= 9'h1FF;
    end else begin
      prbs_q <= prbs_nxt;
    end
  end

  assign gen3 = prbs_word;
`else
  assign gen3 = 10'b1010101010;
`endif

  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      case (mode_eff)
        2'd0:    src[ch] = bus.din[10*ch +: 10];
        2'd1:    src[ch] = ramp_q;
        2'd2:    src[ch] = bus.pattern;
        default: src[ch] = gen3;
      endcase
    end
  end

  always_ff @(posedge sclk2_in) begin
    if (rst) begin
      phase_q    <= 1'b0;
      sync_q     <= 1'b0;
      sync_out_q <= 1'b0;
      tx_vld     <= 1'b0;
      mode_q     <= 2'd0;
      ramp_q     <= 10'd0;
      for (int ch = 0; ch < NCH; ch++) begin
        cap_a[ch] <= 10'd0;
        tx_a[ch]  <= 10'd0;
        tx_b[ch]  <= 10'd0;
      end
    end else begin
      sync_q     <= bus.sync;
      sync_out_q <= sync_edge;
      if (sync_edge) begin
        phase_q <= 1'b0;
        ramp_q  <= 10'd0;
        tx_vld  <= 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin
          cap_a[ch] <= 10'd0;
          tx_a[ch]  <= 10'd0;
          tx_b[ch]  <= 10'd0;
        end
      end else begin
        phase_q <= ~phase_q;
        ramp_q  <= ramp_q + RAMP_INC;
        if (!phase_q) begin
          mode_q <= bus.mode;
          cap_a  <= src;
        end else begin
          tx_a   <= cap_a;
          tx_b   <= src;
          tx_vld <= 1'b1;
        end
      end
    end
  end

  // Upper chunk goes out in phase 0 right after the load, lower chunk in phase 1.
  always_comb begin
    bus.lane_bits = '0;
    bus.fclk_bits = 5'b00000;
    if (tx_vld) begin
      bus.fclk_bits = phase_q ? 5'b00000 : 5'b11111;
      for (int ch = 0; ch < NCH; ch++) begin
        bus.lane_bits[10*ch +: 5]     = phase_q ? tx_a[ch][4:0] : tx_a[ch][9:5];
        bus.lane_bits[10*ch + 5 +: 5] = phase_q ? tx_b[ch][4:0] : tx_b[ch][9:5];
      end
    end
  end

  assign bus.phase    = phase_q;
  assign bus.sync_out = sync_out_q;
endmodule

// File: tb/tb_ads5296_tx_framer.sv
// Directed bench for ads5296_tx_framer with an output scoreboard; honours ADS5296_TX_PRBS_EN.
module tb_ads5296_tx_framer;
  localparam int NU   = 4;
  localparam int STEP = 1;
  localparam int W    = 40 * NU;
  localparam int NCH  = 4 * NU;

  typedef struct packed {
    logic [W-1:0] lanes;
    logic [4:0]   fclk;
  } exp_t;

  logic sclk2_in = 1'b0;
  logic rst      = 1'b1;
  always #5 sclk2_in = ~sclk2_in;

  ads5296_tx_framer_if #(.G_NUM_UNITS(NU)) bus ();

  ads5296_tx_framer #(.G_NUM_UNITS(NU), .G_RAMP_STEP(STEP)) dut (
    .sclk2_in (sclk2_in),
    .rst      (rst),
    .bus      (bus.slave)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  logic       m_phase    = 1'b0;
  logic       m_sync_q   = 1'b0;
  logic       m_sync_out = 1'b0;
  logic [1:0] m_mode_q   = 2'd0;
  logic [9:0] m_ramp     = 10'd0;
  logic [8:0] m_prbs     = 9'h1FF;
  logic [9:0] m_a [NCH];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_din();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W / 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [9:0] prbs_adv(inout logic [8:0] st);
    logic [9:0] w;
    logic       fb;
    w = '0;
    for (int i = 0; i < 10; i++) begin
      fb = st[8] ^ st[4];
      w  = {w[8:0], fb};
      st = {st[7:0], fb};
    end
    return w;
  endfunction

  // One clock: check this cycle's outputs, drive this cycle's inputs, advance the model.
  task automatic step(input logic r, input logic s, input logic [1:0] md,
                      input logic [9:0] pat, input logic [W-1:0] d);
    exp_t       e, hi, lo;
    logic       edge_;
    logic [1:0] em;
    logic [8:0] ps;
    logic [9:0] pw;
    logic [9:0] src [NCH];
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    chk("lane_bits", bus.lane_bits, e.lanes);
    chk("fclk_bits", W'(bus.fclk_bits), W'(e.fclk));
    chk("phase", W'(bus.phase), W'(m_phase));
    chk("sync_out", W'(bus.sync_out), W'(m_sync_out));
    rst         = r;
    bus.sync    = s;
    bus.mode    = md;
    bus.pattern = pat;
    bus.din     = d;
    if (r) begin
      sb.delete();
      m_phase = 1'b0; m_sync_q = 1'b0; m_sync_out = 1'b0;
      m_mode_q = 2'd0; m_ramp = 10'd0; m_prbs = 9'h1FF;
    end else begin
      edge_ = s & ~m_sync_q;
      em    = m_phase ? m_mode_q : md;
      ps    = m_prbs;
      pw    = prbs_adv(ps);
      for (int ch = 0; ch < NCH; ch++) begin
        case (em)
          2'd0:    src[ch] = d[10*ch +: 10];
          2'd1:    src[ch] = m_ramp;
          2'd2:    src[ch] = pat;
`ifdef ADS5296_TX_PRBS_EN
          default: src[ch] = pw;
`else
          default: src[ch] = 10'h2AA;
`endif
        endcase
      end
      if (edge_) begin
        sb.delete();
      end else if (!m_phase) begin
        m_mode_q = md;
        m_a      = src;
      end else begin
        hi = '0; lo = '0;
        hi.fclk = 5'b11111;
        for (int ch = 0; ch < NCH; ch++) begin
          hi.lanes[10*ch +: 5]     = m_a[ch][9:5];
          hi.lanes[10*ch + 5 +: 5] = src[ch][9:5];
          lo.lanes[10*ch +: 5]     = m_a[ch][4:0];
          lo.lanes[10*ch + 5 +: 5] = src[ch][4:0];
        end
        sb.push_back(hi);
        sb.push_back(lo);
      end
      m_sync_out = edge_;
      m_phase    = edge_ ? 1'b0 : ~m_phase;
      m_ramp     = edge_ ? 10'd0 : 10'(m_ramp + 10'(STEP));
      m_prbs     = edge_ ? 9'h1FF : ps;
      m_sync_q   = s;
    end
    @(posedge sclk2_in);
    #1;
  endtask

  task automatic idle(input int n, input logic [1:0] md, input logic [9:0] pat);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, md, pat, rnd_din());
  endtask

  // Called right after a sync edge cycle; reassembles lane0/lane1 words of n pairs.
  task automatic run_pairs(input int n, input logic [1:0] md);
    logic [4:0] h0, h1;
    logic [9:0] w0, w1, e0, e1;
    logic [9:0] prev;
    bit         wrap_seen;
    bit         bits [];
    wrap_seen = 0;
    prev      = '0;
    bits      = new[20 * n + 9];
    for (int i = 0; i < 9; i++) bits[i] = 1'b1;
    for (int i = 9; i < 20 * n + 9; i++) bits[i] = bits[i-9] ^ bits[i-5];
    step(1'b0, 1'b0, md, 10'h000, rnd_din());
    step(1'b0, 1'b0, md, 10'h000, rnd_din());
    for (int i = 0; i < n; i++) begin
      h0 = bus.lane_bits[4:0];
      h1 = bus.lane_bits[9:5];
      step(1'b0, 1'b0, md, 10'h000, rnd_din());
      w0 = {h0, bus.lane_bits[4:0]};
      w1 = {h1, bus.lane_bits[9:5]};
      if (md == 2'd1) begin
        e0 = 10'((2 * i * STEP) % 1024);
        e1 = 10'((2 * i * STEP + STEP) % 1024);
        if (i > 0 && w0 < prev) wrap_seen = 1;
      end else begin
`ifdef ADS5296_TX_PRBS_EN
        for (int b = 0; b < 10; b++) begin
          e0[9-b] = bits[9 + 20*i + b];
          e1[9-b] = bits[19 + 20*i + b];
        end
`else
        e0 = 10'h2AA;
        e1 = 10'h2AA;
`endif
      end
      chk("pair_word_a", W'(w0), W'(e0));
      chk("pair_word_b", W'(w1), W'(e1));
      prev = w0;
      step(1'b0, 1'b0, md, 10'h000, rnd_din());
    end
    if (md == 2'd1) chk("ramp_wrap_seen", W'(wrap_seen), W'(1'b1));
  endtask

  initial begin
    logic [W-1:0] d;
    bus.sync = 1'b0; bus.mode = 2'd0; bus.pattern = 10'h000; bus.din = '0;
    @(posedge sclk2_in);
    #1;
    step(1'b1, 1'b0, 2'd0, 10'h000, '0);

    // Pass-through with random samples
    idle(20, 2'd0, 10'h000);

    // Fixed pattern, sync taken in a phase-1 cycle
    if (!m_phase) step(1'b0, 1'b0, 2'd2, 10'h3A5, rnd_din());
    step(1'b0, 1'b1, 2'd2, 10'h3A5, rnd_din());
    chk("sync_out_pulse", W'(bus.sync_out), W'(1'b1));
    step(1'b0, 1'b0, 2'd2, 10'h3A5, rnd_din());
    step(1'b0, 1'b0, 2'd2, 10'h3A5, rnd_din());
    chk("pattern_hi_chunk", W'(bus.lane_bits[4:0]), W'(5'b11101));
    chk("pattern_hi_fclk", W'(bus.fclk_bits), W'(5'b11111));
    step(1'b0, 1'b0, 2'd2, 10'h3A5, rnd_din());
    chk("pattern_lo_chunk", W'(bus.lane_bits[4:0]), W'(5'b00101));
    chk("pattern_lo_fclk", W'(bus.fclk_bits), W'(5'b00000));
    idle(16, 2'd2, 10'h3A5);

    // Sync held high: a single pulse only
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 2'd2, 10'h0F0, rnd_din());
    idle(8, 2'd2, 10'h0F0);

    // Pass-through directed samples on channel 0
    step(1'b0, 1'b1, 2'd0, 10'h000, rnd_din());
    d = rnd_din(); d[9:0] = 10'h155;
    step(1'b0, 1'b0, 2'd0, 10'h000, d);
    d = rnd_din(); d[9:0] = 10'h2AA;
    step(1'b0, 1'b0, 2'd0, 10'h000, d);
    chk("din_lane0_hi", W'(bus.lane_bits[4:0]), W'(5'b01010));
    chk("din_lane1_hi", W'(bus.lane_bits[9:5]), W'(5'b10101));
    step(1'b0, 1'b0, 2'd0, 10'h000, rnd_din());
    chk("din_lane0_lo", W'(bus.lane_bits[4:0]), W'(5'b10101));
    chk("din_lane1_lo", W'(bus.lane_bits[9:5]), W'(5'b01010));
    idle(6, 2'd0, 10'h000);

    // Ramp with sync in a phase-0 cycle
    if (m_phase) step(1'b0, 1'b0, 2'd1, 10'h000, rnd_din());
    step(1'b0, 1'b1, 2'd1, 10'h000, rnd_din());
    chk("ramp_sync_out", W'(bus.sync_out), W'(1'b1));
    run_pairs(550, 2'd1);

    // Mode 3 (PRBS-9 or deskew word)
    step(1'b0, 1'b1, 2'd3, 10'h000, rnd_din());
    run_pairs(512, 2'd3);
`ifndef ADS5296_TX_PRBS_EN
    if (m_phase) step(1'b0, 1'b0, 2'd3, 10'h000, rnd_din());
    chk("deskew_hi_chunk", W'(bus.lane_bits[4:0]), W'(5'b10101));
    step(1'b0, 1'b0, 2'd3, 10'h000, rnd_din());
    chk("deskew_lo_chunk", W'(bus.lane_bits[4:0]), W'(5'b01010));
`endif

    // Reset mid-pair with sync high
    idle(5, 2'd0, 10'h000);
    if (!m_phase) step(1'b0, 1'b0, 2'd0, 10'h000, rnd_din());
    step(1'b1, 1'b1, 2'd0, 10'h000, rnd_din());
    chk("rst_lanes_zero", bus.lane_bits, '0);
    chk("rst_fclk_zero", W'(bus.fclk_bits), W'(5'b00000));
    chk("rst_sync_out_zero", W'(bus.sync_out), W'(1'b0));
    step(1'b1, 1'b0, 2'd0, 10'h000, rnd_din());
    chk("rel_phase_zero", W'(bus.phase), W'(1'b0));
    idle(8, 2'd0, 10'h000);
    step(1'b0, 1'b1, 2'd0, 10'h000, rnd_din());
    chk("post_rst_sync_pulse", W'(bus.sync_out), W'(1'b1));
    idle(6, 2'd0, 10'h000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
